sprite_compositor: RTL and testbench

- Parametrised, pipelined successor to the fixed-layout play-screen renderer.
- Composites N run-time-configurable sprite slots over a background colour.
- Each slot has position, size, power-of-two scale, sprite-ROM base, 3-colour palette and transparency.
- Sits between the VGA timing counters and the VGA colour output.
- Drives one external synchronous 2-bit sprite ROM port per slot.

---
 rtl/sprite_compositor.sv | 179 +++++++++++++++++
 tb/tb_sprite_compositor.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_compositor.sv
// Layered sprite compositor: N configurable slots over a background colour,
// three-stage pipeline from VGA counters to RGB444 output.
module sprite_compositor #(
    parameter int N_SPRITES = 8,
    parameter int COORD_W   = 10,
    parameter int ADDR_W    = 13,
    parameter int IDX_W     = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [COORD_W-1:0]            h_cnt,
    input  logic [COORD_W-1:0]            v_cnt,
    input  logic                          frame_start,
    input  logic [11:0]                   bg_color,
    input  logic                          cfg_we,
    input  logic [IDX_W-1:0]              cfg_idx,
    input  logic                          cfg_en,
    input  logic [COORD_W-1:0]            cfg_x,
    input  logic [COORD_W-1:0]            cfg_y,
    input  logic [7:0]                    cfg_w,
    input  logic [7:0]                    cfg_h,
    input  logic [1:0]                    cfg_shift,
    input  logic [ADDR_W-1:0]             cfg_base,
    input  logic [35:0]                   cfg_pal,
    output logic [N_SPRITES*ADDR_W-1:0]   rom_addr,
    input  logic [N_SPRITES*2-1:0]        rom_data,
    output logic [11:0]                   pixel,
    output logic                          pixel_valid,
    output logic                          hit_any,
    output logic [IDX_W-1:0]              hit_idx
);

    // in_valid/pixel_valid form a fixed-latency stream with no backpressure:
    // every stage advances every cycle, invalid pixels travel as bubbles.
    localparam int EXT_W = COORD_W + 3;
    localparam int MUL_W = EXT_W + 8;
    localparam logic [IDX_W:0] N_LIM = (IDX_W + 1)'(N_SPRITES);

    typedef struct packed {
        logic               en;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [7:0]         w;
        logic [7:0]         h;
        logic [1:0]         shift;
        logic [ADDR_W-1:0]  base;
        logic [35:0]        pal;
    } slot_cfg_t;

    slot_cfg_t shadow_tbl [N_SPRITES];
    slot_cfg_t active_tbl [N_SPRITES];
    slot_cfg_t cfg_slot;

    assign cfg_slot = {cfg_en, cfg_x, cfg_y, cfg_w, cfg_h, cfg_shift, cfg_base, cfg_pal};

    // Copy reads the pre-write shadow, so a same-cycle write lands a frame later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SPRITES; i++) begin
                shadow_tbl[i] <= '0;
                active_tbl[i] <= '0;
            end
        end else begin
            if (frame_start) begin
                for (int i = 0; i < N_SPRITES; i++) begin
                    active_tbl[i] <= shadow_tbl[i];
                end
            end
            if (cfg_we && ({1'b0, cfg_idx} < N_LIM)) begin
                shadow_tbl[cfg_idx] <= cfg_slot;
            end
        end
    end

    logic [N_SPRITES-1:0] hit_c;
    logic [ADDR_W-1:0]    addr_c [N_SPRITES];

    for (genvar g = 0; g < N_SPRITES; g++) begin : g_slot
        logic [EXT_W-1:0] rel_x;
        logic [EXT_W-1:0] rel_y;
        logic [EXT_W-1:0] span_w;
        logic [EXT_W-1:0] span_h;
        logic [EXT_W-1:0] tex_x;
        logic [EXT_W-1:0] tex_y;
        logic [MUL_W-1:0] offset;

        assign rel_x  = EXT_W'(h_cnt) - EXT_W'(active_tbl[g].x);
        assign rel_y  = EXT_W'(v_cnt) - EXT_W'(active_tbl[g].y);
        assign span_w = EXT_W'(active_tbl[g].w) << active_tbl[g].shift;
        assign span_h = EXT_W'(active_tbl[g].h) << active_tbl[g].shift;
        assign tex_x  = rel_x >> active_tbl[g].shift;
        assign tex_y  = rel_y >> active_tbl[g].shift;

        // The >= guards stop a negative offset wrapping into a hit.
        assign hit_c[g] = active_tbl[g].en
                        && (h_cnt >= active_tbl[g].x) && (v_cnt >= active_tbl[g].y)
                        && (rel_x < span_w) && (rel_y < span_h);

        assign offset    = MUL_W'(tex_y) * MUL_W'(active_tbl[g].w) + MUL_W'(tex_x);
        assign addr_c[g] = ADDR_W'(MUL_W'(active_tbl[g].base) + offset);
    end

    logic                 valid1, valid2;
    logic [11:0]          bg1, bg2;
    logic [N_SPRITES-1:0] hit1, hit2;
    logic [35:0]          pal1 [N_SPRITES];
    logic [35:0]          pal2 [N_SPRITES];

    // Palettes ride with the pixel so a table swap never mixes frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid1   <= 1'b0;
            valid2   <= 1'b0;
            bg1      <= '0;
            bg2      <= '0;
            hit1     <= '0;
            hit2     <= '0;
            rom_addr <= '0;
            for (int i = 0; i < N_SPRITES; i++) begin
                pal1[i] <= '0;
                pal2[i] <= '0;
            end
        end else begin
            valid1 <= in_valid;
            bg1    <= bg_color;
            hit1   <= hit_c;
            valid2 <= valid1;
            bg2    <= bg1;
            hit2   <= hit1;
            for (int i = 0; i < N_SPRITES; i++) begin
                pal1[i] <= active_tbl[i].pal;
                pal2[i] <= pal1[i];
                if (hit_c[i]) begin
                    rom_addr[i*ADDR_W +: ADDR_W] <= addr_c[i];
                end
            end
        end
    end

    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [11:0]      win_color;
    logic [1:0]       code;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_color = bg2;
        code      = 2'b00;
        for (int i = 0; i < N_SPRITES; i++) begin
            code = rom_data[i*2 +: 2];
            if (!win_found && hit2[i] && (code != 2'b11)) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
                case (code)
                    2'b00:   win_color = pal2[i][11:0];
                    2'b01:   win_color = pal2[i][23:12];
                    default: win_color = pal2[i][35:24];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel       <= '0;
            pixel_valid <= 1'b0;
            hit_any     <= 1'b0;
            hit_idx     <= '0;
        end else begin
            pixel_valid <= valid2;
            pixel       <= valid2 ? win_color : 12'h000;
            hit_any     <= valid2 && win_found;
            hit_idx     <= (valid2 && win_found) ? win_idx : '0;
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: vector table plus hand sequences, outputs
// checked through a due-cycle scoreboard queue.
module tb_sprite_compositor;
  localparam int N  = 8;
  localparam int CW = 10;
  localparam int AW = 13;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic [CW-1:0]   h_cnt, v_cnt;
  logic            frame_start;
  logic [11:0]     bg_color;
  logic            cfg_we;
  logic [IW-1:0]   cfg_idx;
  logic            cfg_en;
  logic [CW-1:0]   cfg_x, cfg_y;
  logic [7:0]      cfg_w, cfg_h;
  logic [1:0]      cfg_shift;
  logic [AW-1:0]   cfg_base;
  logic [35:0]     cfg_pal;
  logic [N*AW-1:0] rom_addr;
  logic [N*2-1:0]  rom_data;
  logic [11:0]     pixel;
  logic            pixel_valid;
  logic            hit_any;
  logic [IW-1:0]   hit_idx;

  sprite_compositor #(.N_SPRITES(N), .COORD_W(CW), .ADDR_W(AW), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .frame_start(frame_start), .bg_color(bg_color), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_en(cfg_en), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_w(cfg_w), .cfg_h(cfg_h),
    .cfg_shift(cfg_shift), .cfg_base(cfg_base), .cfg_pal(cfg_pal), .rom_addr(rom_addr),
    .rom_data(rom_data), .pixel(pixel), .pixel_valid(pixel_valid), .hit_any(hit_any),
    .hit_idx(hit_idx)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  logic [32:0] exp_q[$];
  logic [32:0] ent;

  localparam logic [35:0] PAL0 = {12'hf00, 12'h0f0, 12'h00f};
  localparam logic [35:0] PAL1 = {12'h777, 12'h123, 12'h456};
  localparam logic [35:0] PAL2 = {12'h888, 12'h0a0, 12'h555};
  localparam logic [35:0] PAL3 = {12'h333, 12'h444, 12'hfff};

  typedef struct packed {
    logic          vld;
    logic [CW-1:0] h;
    logic [CW-1:0] v;
    logic [16:0]   exp;
  } vec_t;
  vec_t vecs [14];

  function automatic logic [16:0] mk(input logic v, input logic hit, input logic [2:0] idx,
                                     input logic [11:0] p);
    return {v, hit, idx, p};
  endfunction

  logic [16:0] bg_exp, off_exp, s0_exp, s2_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard: each entry is due exactly three edges after it was driven
  always @(posedge clk) begin
    #2;
    while (exp_q.size() > 0 && exp_q[0][32:17] <= cyc[15:0]) begin
      ent = exp_q.pop_front();
      check("pixel_out", {15'b0, pixel_valid, hit_any, hit_idx, pixel}, {15'b0, ent[16:0]});
    end
  end

  // driver tasks
  task automatic drive(input logic vld, input logic [CW-1:0] h, input logic [CW-1:0] v,
                       input logic [16:0] exp);
    @(negedge clk);
    in_valid = vld;
    h_cnt    = h;
    v_cnt    = v;
    exp_q.push_back({16'(cyc + 3), exp});
  endtask

  task automatic drain();
    repeat (5) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic cfg_write(input int idx, input logic en, input int x, input int y,
                           input int w, input int h, input int sh, input int base,
                           input logic [35:0] pal, input logic fs);
    @(negedge clk);
    in_valid    = 1'b0;
    cfg_we      = 1'b1;
    cfg_idx     = IW'(idx);
    cfg_en      = en;
    cfg_x       = CW'(x);
    cfg_y       = CW'(y);
    cfg_w       = 8'(w);
    cfg_h       = 8'(h);
    cfg_shift   = 2'(sh);
    cfg_base    = AW'(base);
    cfg_pal     = pal;
    frame_start = fs;
    @(negedge clk);
    cfg_we      = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic frame();
    @(negedge clk);
    in_valid    = 1'b0;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic set_rom(input int slot, input logic [1:0] code);
    rom_data[slot*2 +: 2] = code;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_pixel"}, {20'b0, pixel}, 32'h0);
    check({tag, "_valid"}, {31'b0, pixel_valid}, 32'h0);
    check({tag, "_hit_any"}, {31'b0, hit_any}, 32'h0);
    check({tag, "_hit_idx"}, {29'b0, hit_idx}, 32'h0);
    check({tag, "_rom_addr_or"}, {31'b0, |rom_addr}, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; h_cnt = '0; v_cnt = '0; frame_start = 1'b0;
    bg_color = 12'h2bf; cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_x = '0;
    cfg_y = '0; cfg_w = '0; cfg_h = '0; cfg_shift = '0; cfg_base = '0; cfg_pal = '0;
    rom_data = '1;
    bg_exp  = mk(1'b1, 1'b0, 3'd0, 12'h2bf);
    off_exp = mk(1'b0, 1'b0, 3'd0, 12'h000);
    s0_exp  = mk(1'b1, 1'b1, 3'd0, 12'hf00);
    s2_exp  = mk(1'b1, 1'b1, 3'd2, 12'h0a0);

    vecs[0]  = '{1'b1, 10'd12,  10'd91,  s0_exp};
    vecs[1]  = '{1'b1, 10'd29,  10'd91,  s0_exp};
    vecs[2]  = '{1'b1, 10'd30,  10'd91,  bg_exp};
    vecs[3]  = '{1'b1, 10'd9,   10'd91,  bg_exp};
    vecs[4]  = '{1'b1, 10'd12,  10'd129, s0_exp};
    vecs[5]  = '{1'b1, 10'd12,  10'd130, bg_exp};
    vecs[6]  = '{1'b0, 10'd12,  10'd91,  off_exp};
    vecs[7]  = '{1'b1, 10'd113, 10'd297, s2_exp};
    vecs[8]  = '{1'b1, 10'd204, 10'd297, s2_exp};
    vecs[9]  = '{1'b1, 10'd205, 10'd297, bg_exp};
    vecs[10] = '{1'b1, 10'd104, 10'd297, bg_exp};
    vecs[11] = '{1'b1, 10'd113, 10'd369, s2_exp};
    vecs[12] = '{1'b1, 10'd113, 10'd370, bg_exp};
    vecs[13] = '{1'b1, 10'd113, 10'd289, bg_exp};

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;

    // no slots configured: background everywhere, random positions
    for (int i = 0; i < 8; i++)
      drive(1'b1, CW'($urandom_range(0, 639)), CW'($urandom_range(0, 479)), bg_exp);
    drive(1'b0, 10'd0, 10'd0, off_exp);
    drain();

    // slots 0 and 2, then the vector table
    cfg_write(0, 1'b1, 10, 90, 20, 40, 0, 0, PAL0, 1'b0);
    cfg_write(2, 1'b1, 105, 290, 25, 20, 2, 100, PAL2, 1'b0);
    frame();
    set_rom(0, 2'b10);
    set_rom(2, 2'b01);
    for (int i = 0; i < 14; i++) drive(vecs[i].vld, vecs[i].h, vecs[i].v, vecs[i].exp);
    drain();

    // ROM address generation and hold-on-miss
    drive(1'b1, 10'd12, 10'd91, s0_exp);
    @(posedge clk); #2;
    check("rom_addr0", {19'b0, rom_addr[0*AW +: AW]}, 32'd22);
    drive(1'b1, 10'd113, 10'd297, s2_exp);
    @(posedge clk); #2;
    check("rom_addr2", {19'b0, rom_addr[2*AW +: AW]}, 32'd127);
    check("rom_addr0_hold", {19'b0, rom_addr[0*AW +: AW]}, 32'd22);
    drive(1'b1, 10'd205, 10'd297, bg_exp);
    @(posedge clk); #2;
    check("rom_addr2_hold", {19'b0, rom_addr[2*AW +: AW]}, 32'd127);
    drain();

    // overlapping slots 1 and 3: transparency and priority
    cfg_write(1, 1'b1, 300, 10, 16, 16, 1, 500, PAL1, 1'b0);
    cfg_write(3, 1'b1, 310, 20, 8, 8, 0, 900, PAL3, 1'b0);
    frame();
    set_rom(1, 2'b11);
    set_rom(3, 2'b00);
    drive(1'b1, 10'd312, 10'd22, mk(1'b1, 1'b1, 3'd3, 12'hfff));
    drive(1'b1, 10'd305, 10'd15, bg_exp);
    drain();
    set_rom(1, 2'b01);
    drive(1'b1, 10'd312, 10'd22, mk(1'b1, 1'b1, 3'd1, 12'h123));
    drive(1'b1, 10'd305, 10'd15, mk(1'b1, 1'b1, 3'd1, 12'h123));
    drive(1'b1, 10'd318, 10'd22, mk(1'b1, 1'b1, 3'd1, 12'h123));
    drain();

    // shadow/active table timing
    drive(1'b1, 10'd12, 10'd91, s0_exp);
    cfg_write(0, 1'b0, 10, 90, 20, 40, 0, 0, PAL0, 1'b0);
    drive(1'b1, 10'd12, 10'd91, s0_exp);
    drain();
    frame();
    drive(1'b1, 10'd12, 10'd91, bg_exp);
    cfg_write(0, 1'b1, 10, 90, 20, 40, 0, 0, PAL0, 1'b1);
    drive(1'b1, 10'd12, 10'd91, bg_exp);
    drain();
    frame();
    drive(1'b1, 10'd12, 10'd91, s0_exp);
    drive(1'b1, 10'd12, 10'd91, s0_exp);
    drive(1'b1, 10'd12, 10'd91, s0_exp);

    // asynchronous reset mid-line
    @(posedge clk); #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_idle_outputs("midreset");
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    frame();
    drive(1'b0, 10'd12, 10'd91, off_exp);
    drive(1'b0, 10'd12, 10'd91, off_exp);
    drive(1'b1, 10'd12, 10'd91, bg_exp);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #2;
      check($sformatf("latency_edge%0d", k), {31'b0, pixel_valid}, (k == 3) ? 32'd1 : 32'd0);
    end
    drain();

    check("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
